// File: rtl/pulse_receiver_duration_capture_pkg.sv
// Shared definitions for the pulse receiver: FSM state encodings and
// record field placement helpers.
package pulse_receiver_duration_capture_pkg;

  // Capture FSM encodings
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_FIRST = 2'd1;
  localparam logic [1:0] ST_MEASURE    = 2'd2;
  localparam logic [1:0] ST_TIMED_OUT  = 2'd3;

  // Duration occupies the low bits of a record
  localparam int REC_DUR_LSB = 0;

  // Level bit sits directly above the duration field
  function automatic int rec_level_bit(input int timer_width);
    return timer_width;
  endfunction

  // Timeout flag is the record MSB
  function automatic int rec_timeout_bit(input int timer_width);
    return timer_width + 1;
  endfunction

endpackage

// File: rtl/pulse_receiver_record_fifo.sv
// Small synchronous record FIFO with first-word-fall-through head.
// A push while full is accepted only when a pop happens in the same cycle.
module pulse_receiver_record_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Head is presented combinationally; forced to zero while empty
  assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];

  // Storage write; contents need no reset since the head is masked when empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pulse_receiver_duration_capture.sv
// Measures constant-level segments on rx_in in prescaled ticks and queues
// {timeout, level, duration} records for the CPU side.
module pulse_receiver_duration_capture
  import pulse_receiver_duration_capture_pkg::*;
#(
  parameter int PRESCALER_WIDTH = 16,
  parameter int TIMER_WIDTH     = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                               clk,
  input  logic                               sys_rst,
  input  logic                               en,
  input  logic [$clog2(PRESCALER_WIDTH)-1:0] prescaler,
  input  logic                               rx_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [TIMER_WIDTH+1:0]             out_data,
  output logic                               overflow,
  input  logic                               clr_overflow
);

  localparam int REC_W           = TIMER_WIDTH + 2;
  localparam int REC_LEVEL_BIT   = rec_level_bit(TIMER_WIDTH);
  localparam int REC_TIMEOUT_BIT = rec_timeout_bit(TIMER_WIDTH);

  logic [SYNC_STAGES-1:0]     sync_reg;
  logic                       rx_s;
  logic                       rx_prev_reg;
  logic                       edge_det;
  logic [1:0]                 state_reg, state_next;
  logic [PRESCALER_WIDTH-1:0] pre_cnt_reg, pre_cnt_next;
  logic [PRESCALER_WIDTH-1:0] pre_max;
  // Extra MSB flags a duration that no longer fits the record field
  logic [TIMER_WIDTH:0]       dur_cnt_reg, dur_cnt_next;
  // The first tick of a segment is absorbed so the counter holds the reported value
  logic                       first_tick_reg, first_tick_next;
  logic                       push;
  logic [REC_W-1:0]           push_data;
  logic                       pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       drop;
  logic                       overflow_reg;

  assign rx_s     = sync_reg[SYNC_STAGES-1];
  assign edge_det = rx_s ^ rx_prev_reg;
  assign pre_max  = (PRESCALER_WIDTH'(1) << prescaler) - PRESCALER_WIDTH'(1);

  // Line synchronizer plus one-cycle history for edge detection
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      sync_reg    <= '0;
      rx_prev_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], rx_in};
      rx_prev_reg <= rx_s;
    end
  end

  // Capture FSM, tick counters and record generation
  always_comb begin
    state_next      = state_reg;
    pre_cnt_next    = pre_cnt_reg;
    dur_cnt_next    = dur_cnt_reg;
    first_tick_next = first_tick_reg;
    push            = 1'b0;
    push_data       = '0;
    case (state_reg)
      ST_IDLE: begin
        pre_cnt_next    = '0;
        dur_cnt_next    = '0;
        first_tick_next = 1'b0;
        if (en) state_next = ST_WAIT_FIRST;
      end
      ST_WAIT_FIRST: begin
        if (edge_det) begin
          state_next      = ST_MEASURE;
          pre_cnt_next    = '0;
          dur_cnt_next    = '0;
          first_tick_next = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (dur_cnt_reg[TIMER_WIDTH]) begin
          // Saturated: report a timeout; an edge this cycle closes the segment too
          push                                                  = 1'b1;
          push_data[REC_TIMEOUT_BIT]                            = 1'b1;
          push_data[REC_LEVEL_BIT]                              = rx_prev_reg;
          push_data[REC_DUR_LSB +: TIMER_WIDTH]                 = '1;
          pre_cnt_next                                          = '0;
          dur_cnt_next                                          = '0;
          first_tick_next                                       = 1'b0;
          state_next = edge_det ? ST_MEASURE : ST_TIMED_OUT;
        end else if (edge_det) begin
          push                                  = 1'b1;
          push_data[REC_LEVEL_BIT]              = rx_prev_reg;
          push_data[REC_DUR_LSB +: TIMER_WIDTH] = dur_cnt_reg[TIMER_WIDTH-1:0];
          pre_cnt_next                          = '0;
          dur_cnt_next                          = '0;
          first_tick_next                       = 1'b0;
        end else if (pre_cnt_reg == pre_max) begin
          pre_cnt_next = '0;
          if (first_tick_reg) dur_cnt_next = dur_cnt_reg + (TIMER_WIDTH+1)'(1);
          else                first_tick_next = 1'b1;
        end else begin
          pre_cnt_next = pre_cnt_reg + PRESCALER_WIDTH'(1);
        end
      end
      ST_TIMED_OUT: begin
        if (edge_det) begin
          state_next      = ST_MEASURE;
          pre_cnt_next    = '0;
          dur_cnt_next    = '0;
          first_tick_next = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Disabling abandons any segment in progress; queued records survive
    if (!en) begin
      state_next      = ST_IDLE;
      pre_cnt_next    = '0;
      dur_cnt_next    = '0;
      first_tick_next = 1'b0;
      push            = 1'b0;
    end
  end

  // FSM and counter registers
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_reg      <= ST_IDLE;
      pre_cnt_reg    <= '0;
      dur_cnt_reg    <= '0;
      first_tick_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pre_cnt_reg    <= pre_cnt_next;
      dur_cnt_reg    <= dur_cnt_next;
      first_tick_reg <= first_tick_next;
    end
  end

  assign pop  = out_ready & ~fifo_empty;
  assign drop = push & fifo_full & ~pop;

  pulse_receiver_record_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sticky drop flag; a new drop wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (sys_rst)           overflow_reg <= 1'b0;
    else if (drop)         overflow_reg <= 1'b1;
    else if (clr_overflow) overflow_reg <= 1'b0;
  end

  assign out_valid = ~fifo_empty;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_pulse_receiver_duration_capture.sv
// Directed bench for the pulse receiver: segment timing, prescaling,
// timeout, FIFO overflow, enable handling and reset.
module tb_pulse_receiver_duration_capture;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       en;
  logic [3:0] prescaler;
  logic       rx_in;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic       overflow;
  logic       clr_overflow;

  int n_checks = 0;
  int n_fails  = 0;

  pulse_receiver_duration_capture #(
    .PRESCALER_WIDTH (16),
    .TIMER_WIDTH     (8),
    .FIFO_DEPTH      (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .en           (en),
    .prescaler    (prescaler),
    .rx_in        (rx_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rearm();
    en = 1'b0;
    cyc(1);
    en = 1'b1;
    cyc(2);
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] exp);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, 32'(out_data), exp);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
  endtask

  logic lvl;
  logic v0;

  initial begin
    sys_rst = 1'b1; en = 1'b0; prescaler = 4'd0; rx_in = 1'b0;
    out_ready = 1'b0; clr_overflow = 1'b0;
    cyc(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);

    // p=0: 5-cycle high segment -> {0,1,3}, visible one cycle after the edge cycle
    sys_rst = 1'b0; en = 1'b1;
    cyc(2);
    rx_in = 1'b1;
    cyc(5);
    rx_in = 1'b0;
    cyc(2);
    check("lat_early", 32'(out_valid), 32'd0);
    cyc(1);
    pop_expect("p0_len5", 32'h103);
    check("p0_drained", 32'(out_valid), 32'd0);

    // p=2: lengths 17, 6, 16, then 4
    en = 1'b0; cyc(1); prescaler = 4'd2; en = 1'b1; cyc(2);
    rx_in = 1'b1; cyc(17);
    rx_in = 1'b0; cyc(6);
    rx_in = 1'b1; cyc(16);
    rx_in = 1'b0; cyc(3);
    pop_expect("p2_len17", 32'h103);
    pop_expect("p2_len6",  32'h000);
    pop_expect("p2_len16", 32'h102);
    check("p2_drained", 32'(out_valid), 32'd0);
    rearm();
    rx_in = 1'b1; cyc(4);
    rx_in = 1'b0; cyc(3);
    pop_expect("p2_len4", 32'h100);

    // Timeout: low level held 300 cycles with p=0
    en = 1'b0; rx_in = 1'b1; cyc(4);
    prescaler = 4'd0; en = 1'b1; cyc(2);
    rx_in = 1'b0;
    cyc(260);
    check("to_early", 32'(out_valid), 32'd0);
    cyc(1);
    pop_expect("to_rec", 32'h2FF);
    cyc(38);
    rx_in = 1'b1;
    cyc(3);
    check("to_close_silent", 32'(out_valid), 32'd0);
    cyc(2);
    rx_in = 1'b0;
    cyc(3);
    pop_expect("to_next_seg", 32'h103);

    // Overflow: six 3-cycle segments into a 4-deep FIFO
    rearm();
    rx_in = ~rx_in;
    repeat (4) begin
      cyc(3);
      rx_in = ~rx_in;
    end
    cyc(3);
    check("ovf_full_nodrop", 32'(overflow), 32'd0);
    rx_in = ~rx_in;
    cyc(3);
    check("ovf_set", 32'(overflow), 32'd1);
    rx_in = ~rx_in;
    cyc(2);
    clr_overflow = 1'b1; cyc(1); clr_overflow = 1'b0;
    check("ovf_clr_vs_drop", 32'(overflow), 32'd1);
    cyc(1);
    clr_overflow = 1'b1; cyc(1); clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    pop_expect("ovf_rec1", 32'h101);
    pop_expect("ovf_rec2", 32'h001);
    pop_expect("ovf_rec3", 32'h101);
    pop_expect("ovf_rec4", 32'h001);
    check("ovf_drained", 32'(out_valid), 32'd0);

    // Enable dropped mid-segment, then restored
    rearm();
    rx_in = ~rx_in;
    cyc(5);
    lvl = rx_in; rx_in = ~rx_in;
    cyc(3);
    check("en_rec_ready", 32'(out_valid), 32'd1);
    cyc(2);
    en = 1'b0; cyc(2); en = 1'b1; cyc(2);
    rx_in = ~rx_in;
    cyc(3);
    pop_expect("en_kept", {22'd0, 1'b0, lvl, 8'd3});
    check("en_no_partial", 32'(out_valid), 32'd0);
    cyc(1);
    lvl = rx_in; rx_in = ~rx_in;
    cyc(3);
    pop_expect("en_resumed", {22'd0, 1'b0, lvl, 8'd3});

    // Edges every cycle: one record per cycle, duration 0
    rearm();
    v0 = rx_in;
    rx_in = ~rx_in; cyc(1);
    rx_in = ~rx_in; cyc(1);
    rx_in = ~rx_in; cyc(1);
    rx_in = ~rx_in;
    cyc(3);
    pop_expect("l1_rec1", {22'd0, 1'b0, ~v0, 8'd0});
    pop_expect("l1_rec2", {22'd0, 1'b0,  v0, 8'd0});
    pop_expect("l1_rec3", {22'd0, 1'b0, ~v0, 8'd0});
    check("l1_drained", 32'(out_valid), 32'd0);

    // Reset with records queued and overflow set
    rearm();
    rx_in = ~rx_in;
    repeat (5) begin
      cyc(3);
      rx_in = ~rx_in;
    end
    cyc(3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_ovf",   32'(overflow),  32'd1);
    sys_rst = 1'b1;
    cyc(1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_data",  32'(out_data),  32'd0);
    check("post_rst_ovf",   32'(overflow),  32'd0);
    sys_rst = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
